// File: rtl/pulse_stretch.sv
// Event pulse stretcher: each accepted strobe becomes a len-cycle high pulse followed by GAP low cycles.
// Define PULSE_STRETCH_QUEUE_EN to queue events that arrive while busy, up to QDEPTH of them; otherwise they are dropped.
module pulse_stretch #(
  parameter int GAP    = 2,
  parameter int QDEPTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       in,
  input  logic [7:0] len,
  output logic       out,
  output logic       busy,
  output logic       overflow
);

  // state    | meaning
  // ST_IDLE  | waiting for an event
  // ST_HIGH  | driving the stretched pulse, len_cnt_q cycles remain
  // ST_GAP   | forced-low spacing, gap_cnt_q cycles remain
  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_GAP} state_t;

  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  if (QDEPTH < 1 || QDEPTH > 255) begin : g_qdepth_check
    $error("pulse_stretch: QDEPTH out of range 1..255");
  end

  state_t          state_q, state_d;
  logic [7:0]      len_cnt_q, len_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            out_q, out_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;

  logic            evt;
  logic            busy_evt;
  logic            last_high;
  logic            last_gap;
  logic            pulse_end;
  logic            replay;
  logic            drop;
  logic [7:0]      len_eff;

  assign evt       = in & en;
  assign busy_evt  = evt && (state_q != ST_IDLE);
  assign last_high = (state_q == ST_HIGH) && (len_cnt_q <= 8'd1);
  assign last_gap  = (state_q == ST_GAP) && (gap_cnt_q <= GW'(1));
  assign pulse_end = (GAP == 0) ? last_high : last_gap;
  assign len_eff   = (len == 8'd0) ? 8'd1 : len;

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam int PW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] QMAX = PW'(QDEPTH);

  logic [PW-1:0]   pending_q, pending_d;
  logic            accept;

  // An event landing on the final cycle is consumed directly by the replay, so pending is net unchanged.
  assign accept = busy_evt && (pending_q != QMAX);
  assign drop   = busy_evt && !accept;
  assign replay = pulse_end && ((pending_q != '0) || accept);

  always_comb begin
    pending_d = pending_q;
    case ({accept, replay})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end
`else
  assign drop   = busy_evt;
  assign replay = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    len_cnt_d = len_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          state_d   = ST_HIGH;
          len_cnt_d = len_eff;
        end
      end
      ST_HIGH: begin
        len_cnt_d = len_cnt_q - 8'd1;
        if (last_high) begin
          if (GAP == 0) begin
            if (replay) begin
              state_d   = ST_HIGH;
              len_cnt_d = len_eff;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - GW'(1);
        if (last_gap) begin
          if (replay) begin
            state_d   = ST_HIGH;
            len_cnt_d = len_eff;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
    ovf_d  = drop;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      len_cnt_q <= '0;
      gap_cnt_q <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_cnt_q <= len_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch (GAP=2, QDEPTH=2); expectations follow PULSE_STRETCH_QUEUE_EN.
// Vector bit k describes the inputs at edge k and the outputs in the cycle that follows it.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       in = 1'b0;
  logic [7:0] len = 8'd0;
  logic       out, busy, overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  pulse_stretch #(.GAP(2), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset), .en(en), .in(in), .len(len),
    .out(out), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    in    = 1'b0;
    en    = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " rst out"}, out, 1'b0);
    chk({tag, " rst busy"}, busy, 1'b0);
    chk({tag, " rst ovf"}, overflow, 1'b0);
    reset = 1'b1;
  endtask

  task automatic run(input string tag, input int n, input logic [7:0] len0, input logic [7:0] len1,
                     input logic [31:0] in_b, input logic [31:0] en_b, input logic [31:0] rst_b,
                     input logic [31:0] out_e, input logic [31:0] busy_e, input logic [31:0] ovf_e);
    do_reset(tag);
    for (int k = 0; k < n; k++) begin
      en    = en_b[k];
      in    = in_b[k];
      reset = ~rst_b[k];
      len   = (k == 0) ? len0 : len1;
      @(posedge clk);
      #1;
      chk($sformatf("%s c%0d out", tag, k + 1), out, out_e[k]);
      chk($sformatf("%s c%0d busy", tag, k + 1), busy, busy_e[k]);
      chk($sformatf("%s c%0d ovf", tag, k + 1), overflow, ovf_e[k]);
    end
    in    = 1'b0;
    en    = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;

    run("single_len3", 10, 8'd3, 8'd3, 32'h1, 32'h1, 32'h0, 32'h7, 32'h1F, 32'h0);
    run("len0", 8, 8'd0, 8'd0, 32'h1, 32'h1, 32'h0, 32'h1, 32'h7, 32'h0);
    run("len_change", 8, 8'd2, 8'd6, 32'h1, 32'h1, 32'h0, 32'h3, 32'hF, 32'h0);
    run("en_off", 10, 8'd3, 8'd3, 32'h3FF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    run("en_drop_mid", 10, 8'd3, 8'd3, 32'h3FF, 32'h1, 32'h0, 32'h7, 32'h1F, 32'h0);

`ifdef PULSE_STRETCH_QUEUE_EN
    run("burst4", 14, 8'd2, 8'd2, 32'hF, 32'hF, 32'h0, 32'h333, 32'hFFF, 32'h8);
    run("two_evt", 14, 8'd4, 8'd4, 32'h5, 32'h5, 32'h0, 32'h3CF, 32'hFFF, 32'h0);
    run("rst_mid", 12, 8'd5, 8'd5, 32'h3, 32'h3, 32'h8, 32'h7, 32'h7, 32'h0);
    run("evt_at_end", 14, 8'd3, 8'd3, 32'h21, 32'h21, 32'h0, 32'hE7, 32'h3FF, 32'h0);
`else
    run("burst4", 14, 8'd2, 8'd2, 32'hF, 32'hF, 32'h0, 32'h3, 32'hF, 32'hE);
    run("two_evt", 14, 8'd4, 8'd4, 32'h5, 32'h5, 32'h0, 32'hF, 32'h3F, 32'h4);
    run("rst_mid", 12, 8'd5, 8'd5, 32'h3, 32'h3, 32'h8, 32'h7, 32'h7, 32'h2);
    run("evt_at_end", 14, 8'd3, 8'd3, 32'h61, 32'h61, 32'h0, 32'h1C7, 32'h7DF, 32'h20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter GAP, default 2: number of forced-low cycles after each output pulse; 0 permitted.
REQ-002 Parameter QDEPTH, default 3: maximum pending events held when PULSE_STRETCH_QUEUE_EN is defined; range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; the block resets when reset is low at a rising clk edge.
REQ-005 en  input  1  event-accept enable.
REQ-006 in  input  1  single-cycle event strobe, e.g. from an edge detector.
REQ-007 len  input  8  output pulse length in cycles, sampled when a pulse starts.
REQ-008 out  output  1  registered stretched pulse.
REQ-009 busy  output  1  registered; high in HIGH and GAP states.
REQ-010 overflow  output  1  registered; one-cycle flag for a dropped event.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, HIGH, GAP.
REQ-012 An event SHALL be in=1 and en=1 at a clk edge; with en=0, in SHALL be ignored entirely, with no queueing and no overflow.
REQ-013 An event in IDLE SHALL move to HIGH, with out=1 from the next cycle, for L cycles, where L = len sampled at that edge, and len=0 treated as L=1.
REQ-014 After L HIGH cycles the FSM SHALL enter GAP with out=0 for GAP cycles, then return to IDLE; with GAP=0 it SHALL go directly from HIGH to IDLE or the next pulse.
REQ-015 At the final GAP cycle (or the final HIGH cycle if GAP=0), if pending>0 the FSM SHALL re-enter HIGH, decrement pending, and resample len; otherwise it SHALL enter IDLE.
REQ-016 An event in HIGH or GAP SHALL be handled per REQ-024/REQ-025.
REQ-017 If an event coincides with a pending decrement, the pending count SHALL be net unchanged.
REQ-018 An event on the exact edge the FSM enters IDLE SHALL be treated as an IDLE event only if the FSM is in IDLE at that edge; otherwise REQ-016 applies.
REQ-019 The length counter SHALL be 8 bits and count down; len changes mid-pulse SHALL have no effect.
REQ-020 Deasserting en SHALL NOT abort an in-progress pulse, gap, or queued replay.
REQ-021 overflow SHALL assert for exactly one cycle, the cycle after the dropped event; repeated drops SHALL give repeated one-cycle flags.

Reset
REQ-022 On reset low at an edge, the next cycle SHALL have: state=IDLE, out=0, busy=0, overflow=0, pending=0, length and gap counters=0.
REQ-023 Reset mid-pulse SHALL terminate the pulse immediately, and any queued events SHALL be discarded.

Configuration
REQ-024 With macro PULSE_STRETCH_QUEUE_EN defined: an event in HIGH/GAP SHALL increment a saturating pending counter (width ceil(log2(QDEPTH+1))); an event arriving at pending=QDEPTH SHALL be dropped and flag overflow.
REQ-025 With PULSE_STRETCH_QUEUE_EN undefined: no pending counter; every event in HIGH/GAP SHALL be dropped and flag overflow; QDEPTH SHALL be unused.

Verification
REQ-026 len=3, GAP=2, single event at edge 0 -> out=1 cycles 1-3; busy=1 cycles 1-5; IDLE at cycle 6; overflow never set.
REQ-027 len=0, single event -> out=1 exactly one cycle, followed by 2 gap cycles.
REQ-028 QUEUE_EN, QDEPTH=2, len=2, events at edges 0,1,2,3 -> pulses at cycles 1-2, 5-6, 9-10; overflow=1 at cycle 4 only.
REQ-029 QUEUE_EN off, len=4, events at edges 0 and 2 -> one pulse, cycles 1-4; overflow=1 at cycle 3.
REQ-030 len=5, event at edge 0, reset low at edge 3 -> out=0 and busy=0 from cycle 4; an event queued at edge 1 is never replayed.
REQ-031 en=0 with in strobes every cycle for 10 cycles -> out, busy, overflow stay 0.
